// File: rtl/dmem_responder.sv
// Single-port data-memory responder: one outstanding request, fixed LAT-cycle
// access latency, byte-lane stores, misaligned/out-of-range error reporting.
module dmem_responder #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [3:0]    req_be,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err
);

    localparam int unsigned IW = AW - 2;
    localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;
    localparam int unsigned NB = DW / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [DW-1:0]   mem_q [DEPTH];

    logic            accept_c;
    logic            access_c;
    logic            rsp_done_c;
    logic [IW-1:0]   idx_c;
    logic [MW-1:0]   widx_c;
    logic            err_c;
    logic            mem_wr_c;
    logic [DW-1:0]   rd_word_c;

    assign accept_c   = req_valid && req_ready_q && (state_q == S_IDLE);
    assign access_c   = (state_q == S_WAIT) && (cnt_q == '0);
    assign rsp_done_c = (state_q == S_RESP) && rsp_valid_q && rsp_ready;

    // Range check uses the full word index so high address bits cannot alias into the array.
    assign idx_c     = addr_q[AW-1:2];
    assign widx_c    = addr_q[MW+1:2];
    assign err_c     = (addr_q[1:0] != 2'b00) || (64'(idx_c) >= 64'(DEPTH));
    assign rd_word_c = mem_q[widx_c];
    assign mem_wr_c  = access_c && we_q && !err_c;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(LAT - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_done_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode, request capture and response data
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        if (accept_c) begin
            we_d    = req_we;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            be_d    = req_be;
        end
        if (access_c) begin
            rsp_err_d   = err_c;
            rsp_rdata_d = (err_c || we_q) ? '0 : rd_word_c;
        end
    end

    // Storage survives reset; only enabled lanes of an in-range store are written.
    always_ff @(posedge clk) begin
        if (mem_wr_c) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) begin
                    mem_q[widx_c][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
